// File: rtl/jtag_bist_debug_sys.sv
// JTAG TAP with IR, 9-cell BSR, bypass, BIST and memory-write DRs; build with IDCODE_EN for a 32-bit IDCODE DR.
// Latency: register updates land on the TCK edge leaving Update-DR/IR; TDO is combinational from current state.
// Backpressure: none; the TAP follows TMS every TCK edge, and runbist is held until the BIST engine reports idle.
module jtag_bist_debug_sys #(
    parameter int IR_W  = 4,
    parameter int SIG_W = 14,
    parameter int AW    = 8,
    parameter int DW    = 8
) (
    input  logic             TCK,
    input  logic             TRST,
    input  logic             TMS,
    input  logic             TDI,
    output logic             TDO,
    input  logic [4:0]       from_SYS_to_BSR,
    output logic [4:0]       from_BSR_to_CL,
    input  logic [3:0]       from_CL_to_BSR,
    output logic [3:0]       from_BSR_to_SYS,
    output logic [AW-1:0]    start_addr,
    output logic [AW-1:0]    end_addr,
    output logic             write_en,
    output logic [AW-1:0]    addr,
    output logic [DW-1:0]    write_data,
    output logic             runbist,
    input  logic             state_idle,
    input  logic [SIG_W-1:0] signature
);

    localparam int NI     = 5;
    localparam int NO     = 4;
    localparam int BSR_W  = NI + NO;
    localparam int BIST_W = 2 * AW;
    localparam int MEM_W  = AW + DW;

    localparam logic [IR_W-1:0] I_EXTEST  = IR_W'(4'b0000);
    localparam logic [IR_W-1:0] I_SAMPLE  = IR_W'(4'b0001);
    localparam logic [IR_W-1:0] I_INTEST  = IR_W'(4'b0010);
    localparam logic [IR_W-1:0] I_RUNBIST = IR_W'(4'b1010);
    localparam logic [IR_W-1:0] I_MEMWR   = IR_W'(4'b0110);
    localparam logic [IR_W-1:0] I_BYPASS  = IR_W'(4'b1111);
`ifdef IDCODE_EN
    localparam logic [IR_W-1:0] I_IDCODE   = IR_W'(4'b1110);
    localparam logic [31:0]     IDCODE_VAL = 32'h1234_5001;
    localparam logic [IR_W-1:0] I_DEFAULT  = I_IDCODE;
`else
    localparam logic [IR_W-1:0] I_DEFAULT  = I_BYPASS;
`endif

    typedef enum logic [3:0] {
        TLR      = 4'd0,
        RTI      = 4'd1,
        SEL_DR   = 4'd2,
        CAP_DR   = 4'd3,
        SH_DR    = 4'd4,
        EX1_DR   = 4'd5,
        PAUSE_DR = 4'd6,
        EX2_DR   = 4'd7,
        UPD_DR   = 4'd8,
        SEL_IR   = 4'd9,
        CAP_IR   = 4'd10,
        SH_IR    = 4'd11,
        EX1_IR   = 4'd12,
        PAUSE_IR = 4'd13,
        EX2_IR   = 4'd14,
        UPD_IR   = 4'd15
    } tap_state_e;

    typedef enum logic [2:0] {
        DR_BYP  = 3'd0,
        DR_BSR  = 3'd1,
        DR_BIST = 3'd2,
        DR_MEM  = 3'd3,
        DR_ID   = 3'd4
    } dr_sel_e;

    tap_state_e state_q, state_d;
    dr_sel_e    dr_sel;

    logic [IR_W-1:0]   ir_q, ir_d;
    logic [IR_W-1:0]   ir_sr_q, ir_sr_d;
    logic              bypass_q, bypass_d;
    logic [BSR_W-1:0]  bsr_sr_q, bsr_sr_d;
    logic [BSR_W-1:0]  bsr_upd_q, bsr_upd_d;
    logic [BIST_W-1:0] bist_sr_q, bist_sr_d;
    logic [MEM_W-1:0]  mem_sr_q, mem_sr_d;
    logic [AW-1:0]     start_addr_q, start_addr_d;
    logic [AW-1:0]     end_addr_q, end_addr_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DW-1:0]     write_data_q, write_data_d;
    logic              write_en_q, write_en_d;
    logic              runbist_q, runbist_d;
`ifdef IDCODE_EN
    logic [31:0]       idcode_sr_q, idcode_sr_d;
`endif

    // TAP next-state table
    always_comb begin
        state_d = state_q;
        case (state_q)
            TLR:      state_d = TMS ? TLR    : RTI;
            RTI:      state_d = TMS ? SEL_DR : RTI;
            SEL_DR:   state_d = TMS ? SEL_IR : CAP_DR;
            CAP_DR:   state_d = TMS ? EX1_DR : SH_DR;
            SH_DR:    state_d = TMS ? EX1_DR : SH_DR;
            EX1_DR:   state_d = TMS ? UPD_DR : PAUSE_DR;
            PAUSE_DR: state_d = TMS ? EX2_DR : PAUSE_DR;
            EX2_DR:   state_d = TMS ? UPD_DR : SH_DR;
            UPD_DR:   state_d = TMS ? SEL_DR : RTI;
            SEL_IR:   state_d = TMS ? TLR    : CAP_IR;
            CAP_IR:   state_d = TMS ? EX1_IR : SH_IR;
            SH_IR:    state_d = TMS ? EX1_IR : SH_IR;
            EX1_IR:   state_d = TMS ? UPD_IR : PAUSE_IR;
            PAUSE_IR: state_d = TMS ? EX2_IR : PAUSE_IR;
            EX2_IR:   state_d = TMS ? UPD_IR : SH_IR;
            UPD_IR:   state_d = TMS ? SEL_DR : RTI;
            default:  state_d = TLR;
        endcase
    end

    always_ff @(posedge TCK) begin
        if (TRST) begin
            state_q <= TLR;
        end else begin
            state_q <= state_d;
        end
    end

    // Unrecognised opcodes fall through to the bypass register
    always_comb begin
        dr_sel = DR_BYP;
        case (ir_q)
            I_EXTEST, I_SAMPLE, I_INTEST: dr_sel = DR_BSR;
            I_RUNBIST:                    dr_sel = DR_BIST;
            I_MEMWR:                      dr_sel = DR_MEM;
`ifdef IDCODE_EN
            I_IDCODE:                     dr_sel = DR_ID;
`endif
            default:                      dr_sel = DR_BYP;
        endcase
    end

    always_comb begin
        ir_d         = ir_q;
        ir_sr_d      = ir_sr_q;
        bypass_d     = bypass_q;
        bsr_sr_d     = bsr_sr_q;
        bsr_upd_d    = bsr_upd_q;
        bist_sr_d    = bist_sr_q;
        mem_sr_d     = mem_sr_q;
        start_addr_d = start_addr_q;
        end_addr_d   = end_addr_q;
        addr_d       = addr_q;
        write_data_d = write_data_q;
        write_en_d   = 1'b0;
        runbist_d    = (ir_q == I_RUNBIST) && (state_q == RTI) && !state_idle;
`ifdef IDCODE_EN
        idcode_sr_d  = idcode_sr_q;
`endif
        case (state_q)
            TLR:    ir_d    = I_DEFAULT;
            CAP_IR: ir_sr_d = IR_W'(1);
            SH_IR:  ir_sr_d = {TDI, ir_sr_q[IR_W-1:1]};
            UPD_IR: ir_d    = ir_sr_q;
            CAP_DR: begin
                case (dr_sel)
                    DR_BSR:  bsr_sr_d  = {from_CL_to_BSR, from_SYS_to_BSR};
                    DR_BIST: bist_sr_d = {{(BIST_W-SIG_W){1'b0}}, signature};
                    DR_MEM:  mem_sr_d  = {addr_q, write_data_q};
`ifdef IDCODE_EN
                    DR_ID:   idcode_sr_d = IDCODE_VAL;
`endif
                    default: bypass_d  = 1'b0;
                endcase
            end
            SH_DR: begin
                case (dr_sel)
                    DR_BSR:  bsr_sr_d  = {TDI, bsr_sr_q[BSR_W-1:1]};
                    DR_BIST: bist_sr_d = {TDI, bist_sr_q[BIST_W-1:1]};
                    DR_MEM:  mem_sr_d  = {TDI, mem_sr_q[MEM_W-1:1]};
`ifdef IDCODE_EN
                    DR_ID:   idcode_sr_d = {TDI, idcode_sr_q[31:1]};
`endif
                    default: bypass_d  = TDI;
                endcase
            end
            UPD_DR: begin
                case (dr_sel)
                    DR_BSR:  bsr_upd_d = bsr_sr_q;
                    DR_BIST: begin
                        start_addr_d = bist_sr_q[AW-1:0];
                        end_addr_d   = bist_sr_q[BIST_W-1:AW];
                    end
                    DR_MEM: begin
                        addr_d       = mem_sr_q[MEM_W-1:DW];
                        write_data_d = mem_sr_q[DW-1:0];
                        write_en_d   = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge TCK) begin
        if (TRST) begin
            ir_q         <= I_DEFAULT;
            ir_sr_q      <= '0;
            bypass_q     <= 1'b0;
            bsr_sr_q     <= '0;
            bsr_upd_q    <= '0;
            bist_sr_q    <= '0;
            mem_sr_q     <= '0;
            start_addr_q <= '0;
            end_addr_q   <= '0;
            addr_q       <= '0;
            write_data_q <= '0;
            write_en_q   <= 1'b0;
            runbist_q    <= 1'b0;
`ifdef IDCODE_EN
            idcode_sr_q  <= '0;
`endif
        end else begin
            ir_q         <= ir_d;
            ir_sr_q      <= ir_sr_d;
            bypass_q     <= bypass_d;
            bsr_sr_q     <= bsr_sr_d;
            bsr_upd_q    <= bsr_upd_d;
            bist_sr_q    <= bist_sr_d;
            mem_sr_q     <= mem_sr_d;
            start_addr_q <= start_addr_d;
            end_addr_q   <= end_addr_d;
            addr_q       <= addr_d;
            write_data_q <= write_data_d;
            write_en_q   <= write_en_d;
            runbist_q    <= runbist_d;
`ifdef IDCODE_EN
            idcode_sr_q  <= idcode_sr_d;
`endif
        end
    end

    always_comb begin
        TDO = 1'b0;
        if (state_q == SH_IR) begin
            TDO = ir_sr_q[0];
        end else if (state_q == SH_DR) begin
            case (dr_sel)
                DR_BSR:  TDO = bsr_sr_q[0];
                DR_BIST: TDO = bist_sr_q[0];
                DR_MEM:  TDO = mem_sr_q[0];
`ifdef IDCODE_EN
                DR_ID:   TDO = idcode_sr_q[0];
`endif
                default: TDO = bypass_q;
            endcase
        end
    end

    // Boundary cells are transparent unless EXTEST/INTEST takes over one side
    always_comb begin
        from_BSR_to_CL  = from_SYS_to_BSR;
        from_BSR_to_SYS = from_CL_to_BSR;
        if (ir_q == I_EXTEST) begin
            from_BSR_to_SYS = bsr_upd_q[BSR_W-1:NI];
        end
        if (ir_q == I_INTEST) begin
            from_BSR_to_CL = bsr_upd_q[NI-1:0];
        end
    end

    assign start_addr = start_addr_q;
    assign end_addr   = end_addr_q;
    assign addr       = addr_q;
    assign write_data = write_data_q;
    assign write_en   = write_en_q;
    assign runbist    = runbist_q;

endmodule

// File: tb/tb_jtag_bist_debug_sys.sv
// Directed bench for jtag_bist_debug_sys: a register-level behavioural model checked every TCK cycle,
// plus hand-computed expectations along the directed sequence.
module tb_jtag_bist_debug_sys;

    logic        TCK = 1'b0;
    logic        TRST, TMS, TDI;
    logic        TDO;
    logic [4:0]  sys_in;
    logic [4:0]  to_cl;
    logic [3:0]  cl_in;
    logic [3:0]  to_sys;
    logic [7:0]  start_addr, end_addr, addr, write_data;
    logic        write_en, runbist, state_idle;
    logic [13:0] signature;

    jtag_bist_debug_sys dut (
        .TCK(TCK), .TRST(TRST), .TMS(TMS), .TDI(TDI), .TDO(TDO),
        .from_SYS_to_BSR(sys_in), .from_BSR_to_CL(to_cl),
        .from_CL_to_BSR(cl_in), .from_BSR_to_SYS(to_sys),
        .start_addr(start_addr), .end_addr(end_addr),
        .write_en(write_en), .addr(addr), .write_data(write_data),
        .runbist(runbist), .state_idle(state_idle), .signature(signature)
    );

    always #5 TCK = ~TCK;

    int n_chk  = 0;
    int n_pass = 0;
    bit run_cmp = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    typedef enum {M_TLR, M_RTI, M_SELDR, M_CAPDR, M_SHDR, M_EX1DR, M_PDR, M_EX2DR, M_UPDDR,
                  M_SELIR, M_CAPIR, M_SHIR, M_EX1IR, M_PIR, M_EX2IR, M_UPDIR} mstate_t;

`ifdef IDCODE_EN
    localparam logic [3:0] M_DEF = 4'b1110;
`else
    localparam logic [3:0] M_DEF = 4'b1111;
`endif

    mstate_t     m_state = M_TLR;
    logic [3:0]  m_ir = M_DEF, m_irsr = '0;
    logic [31:0] m_sr [5];
    int          m_w  [5] = '{1, 9, 16, 16, 32};
    logic [8:0]  m_upd = '0;
    logic [7:0]  m_start = '0, m_end = '0, m_addr = '0, m_wd = '0;
    logic        m_we = 1'b0, m_rb = 1'b0;

    function automatic mstate_t nxt(input mstate_t s, input logic tms);
        case (s)
            M_TLR:   return tms ? M_TLR   : M_RTI;
            M_RTI:   return tms ? M_SELDR : M_RTI;
            M_SELDR: return tms ? M_SELIR : M_CAPDR;
            M_CAPDR, M_SHDR: return tms ? M_EX1DR : M_SHDR;
            M_EX1DR: return tms ? M_UPDDR : M_PDR;
            M_PDR:   return tms ? M_EX2DR : M_PDR;
            M_EX2DR: return tms ? M_UPDDR : M_SHDR;
            M_SELIR: return tms ? M_TLR   : M_CAPIR;
            M_CAPIR, M_SHIR: return tms ? M_EX1IR : M_SHIR;
            M_EX1IR: return tms ? M_UPDIR : M_PIR;
            M_PIR:   return tms ? M_EX2IR : M_PIR;
            M_EX2IR: return tms ? M_UPDIR : M_SHIR;
            default: return tms ? M_SELDR : M_RTI;   // both update states
        endcase
    endfunction

    // 0 bypass, 1 BSR, 2 BIST, 3 memory write, 4 IDCODE
    function automatic int kind(input logic [3:0] ir);
        case (ir)
            4'b0000, 4'b0001, 4'b0010: return 1;
            4'b1010: return 2;
            4'b0110: return 3;
`ifdef IDCODE_EN
            4'b1110: return 4;
`endif
            default: return 0;
        endcase
    endfunction

    always @(posedge TCK) begin
        int  k;
        logic we_n, rb_n;
        if (TRST) begin
            m_state = M_TLR; m_ir = M_DEF; m_irsr = '0; m_upd = '0;
            for (int i = 0; i < 5; i++) m_sr[i] = '0;
            m_start = '0; m_end = '0; m_addr = '0; m_wd = '0; m_we = 1'b0; m_rb = 1'b0;
        end else begin
            k    = kind(m_ir);
            we_n = 1'b0;
            rb_n = (m_ir == 4'b1010) && (m_state == M_RTI) && !state_idle;
            case (m_state)
                M_TLR:   m_ir   = M_DEF;
                M_CAPIR: m_irsr = 4'b0001;
                M_SHIR:  m_irsr = {TDI, m_irsr[3:1]};
                M_UPDIR: m_ir   = m_irsr;
                M_CAPDR: begin
                    case (k)
                        1: m_sr[1] = 32'({cl_in, sys_in});
                        2: m_sr[2] = 32'(signature);
                        3: m_sr[3] = 32'({m_addr, m_wd});
                        4: m_sr[4] = 32'h1234_5001;
                        default: m_sr[0] = 32'd0;
                    endcase
                end
                M_SHDR: m_sr[k] = (m_sr[k] >> 1) | (32'(TDI) << (m_w[k] - 1));
                M_UPDDR: begin
                    if (k == 1) m_upd = m_sr[1][8:0];
                    if (k == 2) begin m_start = m_sr[2][7:0]; m_end = m_sr[2][15:8]; end
                    if (k == 3) begin m_addr = m_sr[3][15:8]; m_wd = m_sr[3][7:0]; we_n = 1'b1; end
                end
                default: ;
            endcase
            m_we    = we_n;
            m_rb    = rb_n;
            m_state = nxt(m_state, TMS);
        end
    end

    // Compare process: every falling edge, all outputs against the model
    always @(negedge TCK) begin
        logic       e_tdo;
        logic [4:0] e_cl;
        logic [3:0] e_sys;
        if (run_cmp) begin
            e_tdo = 1'b0;
            if (m_state == M_SHIR) e_tdo = m_irsr[0];
            if (m_state == M_SHDR) e_tdo = m_sr[kind(m_ir)][0];
            e_cl  = (m_ir == 4'b0010) ? m_upd[4:0] : sys_in;
            e_sys = (m_ir == 4'b0000) ? m_upd[8:5] : cl_in;
            check("model tdo",        32'(TDO),        32'(e_tdo));
            check("model to_cl",      32'(to_cl),      32'(e_cl));
            check("model to_sys",     32'(to_sys),     32'(e_sys));
            check("model start_addr", 32'(start_addr), 32'(m_start));
            check("model end_addr",   32'(end_addr),   32'(m_end));
            check("model addr",       32'(addr),       32'(m_addr));
            check("model write_data", 32'(write_data), 32'(m_wd));
            check("model write_en",   32'(write_en),   32'(m_we));
            check("model runbist",    32'(runbist),    32'(m_rb));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic tms, input logic tdi, output logic tdo_o);
        TMS = tms;
        TDI = tdi;
        #1 tdo_o = TDO;
        @(posedge TCK);
        #2;
    endtask

    task automatic go(input logic tms);
        logic d;
        step(tms, 1'b0, d);
    endtask

    task automatic shift_ir(input logic [3:0] v, output logic [3:0] cap);
        logic t;
        go(1); go(1); go(0); go(0);
        for (int i = 0; i < 4; i++) begin
            step(i == 3, v[i], t);
            cap[i] = t;
        end
        go(1); go(0);
    endtask

    task automatic shift_dr(input int n, input logic [31:0] v, output logic [31:0] cap);
        logic t;
        cap = '0;
        go(1); go(0); go(0);
        for (int i = 0; i < n; i++) begin
            step(i == n - 1, v[i], t);
            cap[i] = t;
        end
        go(1); go(0);
    endtask

    logic [3:0]  ircap;
    logic [31:0] drcap;

    initial begin
        TRST = 1'b1; TMS = 1'b0; TDI = 1'b0;
        sys_in = 5'b01010; cl_in = 4'b1001;
        state_idle = 1'b1;
        signature  = 14'b00101011111010;
        run_cmp    = 1'b1;

        go(0);
        check("rst runbist",  32'(runbist), 32'd0);
        check("rst write_en", 32'(write_en), 32'd0);
        check("rst start",    32'(start_addr), 32'd0);
        check("rst end",      32'(end_addr), 32'd0);
        check("rst to_cl",    32'(to_cl), 32'h0A);
        check("rst to_sys",   32'(to_sys), 32'h9);
        TRST = 1'b0;
        go(0);

        shift_ir(4'b1010, ircap);
        check("ir capture", 32'(ircap), 32'h1);
        shift_dr(16, 32'h0000_A5C3, drcap);
        check("bist sig out", drcap, 32'h0AFA);
        check("end_addr",   32'(end_addr), 32'hA5);
        check("start_addr", 32'(start_addr), 32'hC3);

        state_idle = 1'b0;
        go(0);
        check("runbist on", 32'(runbist), 32'd1);
        state_idle = 1'b1;
        go(0);
        check("runbist idle off", 32'(runbist), 32'd0);
        state_idle = 1'b0;
        go(0); go(1);
        check("runbist last rti", 32'(runbist), 32'd1);
        go(1);
        check("runbist left rti", 32'(runbist), 32'd0);
        state_idle = 1'b1;
        go(1); go(0);

        shift_ir(4'b0110, ircap);
        shift_dr(16, 32'h0000_3C7E, drcap);
        check("mem capture", drcap, 32'h0);
        check("mem addr",  32'(addr), 32'h3C);
        check("mem wdata", 32'(write_data), 32'h7E);
        check("write_en pulse", 32'(write_en), 32'd1);
        go(0);
        check("write_en drop", 32'(write_en), 32'd0);

        shift_ir(4'b0001, ircap);
        shift_dr(9, 32'h0C0, drcap);
        check("bsr sample", drcap, 32'h12A);
        shift_ir(4'b0000, ircap);
        check("extest to_sys", 32'(to_sys), 32'h6);
        check("extest to_cl",  32'(to_cl), 32'h0A);
        shift_ir(4'b0010, ircap);
        check("intest to_cl",  32'(to_cl), 32'h00);
        check("intest to_sys", 32'(to_sys), 32'h9);
        for (int i = 0; i < 5; i++) go(1);
        check("tms reset to_cl",  32'(to_cl), 32'h0A);
        check("tms reset to_sys", 32'(to_sys), 32'h9);
        go(0);

        shift_ir(4'b1111, ircap);
        shift_dr(4, 32'hB, drcap);
        check("bypass stream", drcap, 32'h6);

        shift_ir(4'b0110, ircap);
        go(1); go(0); go(0);
        for (int i = 0; i < 8; i++) go(0);
        TRST = 1'b1;
        go(0);
        check("abort addr",     32'(addr), 32'h0);
        check("abort write_en", 32'(write_en), 32'd0);
        check("abort tdo",      32'(TDO), 32'd0);
        TRST = 1'b0;
        go(0); go(0);

        run_cmp = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/jtag_bist_debug_sys.md
Name: jtag_bist_debug_sys

Overview:
- IEEE 1149.1-style debug block: 16-state TAP controller, 4-bit instruction register, 9-cell boundary-scan register (BSR), bypass register, and a BIST data register.
- BIST data register carries memory-BIST start/end addresses in and the 14-bit BIST signature out.
- Adds a direct memory-write port loaded through JTAG.
- Sits between the chip pins (TCK/TMS/TDI/TDO), the core logic, and the memory-BIST engine.

Parameters:
- IR_W, 4, instruction register width.
- SIG_W, 14, BIST signature width.
- AW, 8, address width (start_addr, end_addr, addr).
- DW, 8, memory write-data width.

Ports:
- TCK  in  1  JTAG clock; all state updates on rising edge.
- TRST  in  1  reset, synchronous to TCK, active-high.
- TMS  in  1  TAP mode select.
- TDI  in  1  serial data in.
- TDO  out  1  serial data out.
- from_SYS_to_BSR  in  5  system pins into the core.
- from_BSR_to_CL  out  5  BSR-driven core-logic inputs.
- from_CL_to_BSR  in  4  core-logic outputs.
- from_BSR_to_SYS  out  4  BSR-driven system pins.
- start_addr  out  8  BIST start address.
- end_addr  out  8  BIST end address.
- write_en  out  1  one-cycle memory write strobe.
- addr  out  8  memory write address.
- write_data  out  8  memory write data.
- runbist  out  1  BIST run request.
- state_idle  in  1  BIST engine idle/done.
- signature  in  14  BIST result signature.

Behaviour:
- Reset: TRST=1 at a TCK edge, or TMS=1 on 5 consecutive edges, forces Test-Logic-Reset.
- Reset values: IR=default instruction; all shift and update registers 0; start_addr=end_addr=addr=write_data=0; write_en=0; runbist=0.
- TAP states and transitions are standard 1149.1 (TLR, RTI, SelDR, CapDR, ShDR, Ex1DR, PauseDR, Ex2DR, UpdDR, SelIR, CapIR, ShIR, Ex1IR, PauseIR, Ex2IR, UpdIR). State is encoded 4-bit binary.
- Shifting: every shift register shifts right, TDI enters the MSB, LSB-first out.
- TDO = LSB of the selected shift register while in ShIR/ShDR, otherwise 0. TDO is combinational, single clock edge only.
- IR: CapIR loads 4'b0001. UpdIR copies the IR shift register into the active IR.
- Instructions (anything else selects BYPASS):
  - 0000 EXTEST
  - 0001 SAMPLE/PRELOAD
  - 0010 INTEST
  - 1010 RUNBIST
  - 0110 MEMWRITE
  - 1111 BYPASS
- BYPASS: 1-bit register; CapDR loads 0.
- BSR is 9 bits: [4:0] input cells, [8:5] output cells.
  - CapDR loads {from_CL_to_BSR, from_SYS_to_BSR}.
  - UpdDR copies the shift stage to the update latches.
  - EXTEST: from_BSR_to_SYS = out-cell latches; from_BSR_to_CL = from_SYS_to_BSR.
  - INTEST: from_BSR_to_CL = in-cell latches; from_BSR_to_SYS = from_CL_to_BSR.
  - All other instructions: transparent, i.e. from_BSR_to_CL = from_SYS_to_BSR and from_BSR_to_SYS = from_CL_to_BSR.
- RUNBIST DR is 16 bits.
  - CapDR loads {2'b00, signature}.
  - UpdDR latches start_addr = sr[7:0] and end_addr = sr[15:8].
  - runbist = 1 while IR=RUNBIST and TAP in RTI and state_idle=0. Deasserts the cycle after state_idle rises or the TAP leaves RTI.
- MEMWRITE DR is 16 bits.
  - CapDR loads {addr, write_data}.
  - UpdDR latches addr = sr[15:8] and write_data = sr[7:0].
  - write_en = 1 for exactly the one TCK cycle after UpdDR.
- Non-selected DRs hold their value. Pause states hold all shift contents.
- TRST asserted mid-shift: aborts, no update occurs, and all registers return to reset values next edge.

Optional Feature:
- Macro IDCODE_EN.
- Defined: adds a 32-bit IDCODE DR with value 32'h1234_5001 (LSB=1), instruction 1110. TLR loads IDCODE as the default instruction.
- Undefined: code 1110 maps to BYPASS and the default instruction after reset is BYPASS.

Test Plan:
- TRST=1 one cycle -> TAP=TLR, runbist=0, write_en=0, start_addr=end_addr=0; BSR transparent (from_BSR_to_CL=5'b01010 for input 01010).
- Shift IR=1010 LSB-first, then UpdDR a 16-bit DR with TDI value 16'hA5C3 -> end_addr=8'hA5, start_addr=8'hC3. The TDO stream during that shift = signature 14'b00101011111010 then 2'b00, LSB first.
- IR=1010, go to RTI with state_idle=0 -> runbist=1. Raise state_idle -> runbist=0 next cycle.
- IR=0110, shift 16'h3C7E and UpdDR -> addr=8'h3C, write_data=8'h7E, write_en high for exactly 1 cycle.
- IR=0001, CapDR with from_CL_to_BSR=4'b1001, from_SYS_to_BSR=5'b01010 -> TDO shifts out 9'b100101010 LSB first.
- IR=0000, preload out cells 4'b0110 -> from_BSR_to_SYS=4'b0110. TMS=1 for 5 edges -> back to TLR and transparent.
